// File: rtl/user_pulser_sequencer.sv
// Descriptor-driven scheduler for the user-domain pulser: queues pulse-train
// descriptors, starts each train, waits for DONE, repeats with gaps, then moves on.
module user_pulser_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       abort_i,
  input  logic                       desc_valid_i,
  output logic                       desc_ready_o,
  input  logic [7:0]                 desc_f1_cnt_i,
  input  logic [7:0]                 desc_f2_cnt_i,
  input  logic [7:0]                 desc_stop_cnt_i,
  input  logic [15:0]                desc_f1_end_i,
  input  logic [15:0]                desc_f1_switch_i,
  input  logic [15:0]                desc_f2_end_i,
  input  logic [15:0]                desc_f2_switch_i,
  input  logic                       desc_invert_i,
  input  logic [7:0]                 desc_repeat_i,
  input  logic [GAP_W-1:0]           desc_gap_i,
  output logic [7:0]                 pls_f1_cnt_o,
  output logic [7:0]                 pls_f2_cnt_o,
  output logic [7:0]                 pls_stop_cnt_o,
  output logic [15:0]                pls_f1_end_o,
  output logic [15:0]                pls_f1_switch_o,
  output logic [15:0]                pls_f2_end_o,
  output logic [15:0]                pls_f2_switch_o,
  output logic                       pls_invert_o,
  output logic                       pls_start_o,
  output logic                       pls_stop_o,
  input  logic [2:0]                 pls_state_i,
  output logic                       busy_o,
  output logic                       train_done_o,
  output logic [$clog2(DEPTH):0]     fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);
  localparam logic [2:0] PLS_DONE = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef struct packed {
    logic [7:0]       f1_cnt;
    logic [7:0]       f2_cnt;
    logic [7:0]       stop_cnt;
    logic [15:0]      f1_end;
    logic [15:0]      f1_switch;
    logic [15:0]      f2_end;
    logic [15:0]      f2_switch;
    logic             invert;
    logic [7:0]       repeat_n;
    logic [GAP_W-1:0] gap;
  } desc_t;

  desc_t            mem_q [DEPTH];
  desc_t            din;
  desc_t            head;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]    fill_q;
  logic [1:0]       state_q, state_d;
  logic [7:0]       rep_q, rep_d, rep_dec;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_q;
  logic             pls_stop_q;
  logic             full, push, pop, done_seen;

  logic [7:0]  f1_cnt_q, f2_cnt_q, stop_cnt_q;
  logic [15:0] f1_end_q, f1_switch_q, f2_end_q, f2_switch_q;
  logic        invert_q;

  assign din = '{
    f1_cnt:    desc_f1_cnt_i,
    f2_cnt:    desc_f2_cnt_i,
    stop_cnt:  desc_stop_cnt_i,
    f1_end:    desc_f1_end_i,
    f1_switch: desc_f1_switch_i,
    f2_end:    desc_f2_end_i,
    f2_switch: desc_f2_switch_i,
    invert:    desc_invert_i,
    repeat_n:  desc_repeat_i,
    gap:       desc_gap_i
  };

  assign head         = mem_q[rd_ptr_q];
  assign full         = (fill_q == FULL_CNT);
  assign desc_ready_o = !full && !abort_i;
  assign push         = desc_valid_i && desc_ready_o;
  // A pop is the IDLE->START decision itself, so it shares the abort veto.
  assign pop          = (state_q == ST_IDLE) && enable_i && (fill_q != '0) && !abort_i;
  assign done_seen    = (state_q == ST_WAIT) && (pls_state_i == PLS_DONE);
  assign rep_dec      = (rep_q != '0) ? rep_q - 8'd1 : 8'd0;

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    gap_cnt_d = gap_cnt_q;
    if (abort_i) begin
      state_d   = ST_IDLE;
      rep_d     = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_d = ST_START;
            rep_d   = (head.repeat_n == '0) ? 8'd1 : head.repeat_n;
          end
        end
        ST_START: state_d = ST_WAIT;
        ST_WAIT: begin
          if (done_seen) begin
            rep_d = rep_dec;
            if (gap_q != '0) begin
              gap_cnt_d = gap_q;
              state_d   = ST_GAP;
            end else begin
              state_d = (rep_dec != '0) ? ST_START : ST_IDLE;
            end
          end
        end
        default: begin
          if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_W'(1);
          // The <=1 test also keeps a stray zero count from stalling here.
          if (gap_cnt_q <= GAP_W'(1)) state_d = (rep_q != '0) ? ST_START : ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rep_q       <= '0;
      gap_cnt_q   <= '0;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      pls_stop_q  <= 1'b0;
      f1_cnt_q    <= '0;
      f2_cnt_q    <= '0;
      stop_cnt_q  <= '0;
      f1_end_q    <= '0;
      f1_switch_q <= '0;
      f2_end_q    <= '0;
      f2_switch_q <= '0;
      invert_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      gap_cnt_q  <= gap_cnt_d;
      pls_stop_q <= abort_i;
      if (abort_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fill_q   <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   fill_q <= fill_q + FW'(1);
          2'b01:   fill_q <= fill_q - FW'(1);
          default: fill_q <= fill_q;
        endcase
      end
      // Config is only rewritten by the next latch; abort leaves it in place.
      if (pop) begin
        f1_cnt_q    <= head.f1_cnt;
        f2_cnt_q    <= head.f2_cnt;
        stop_cnt_q  <= head.stop_cnt;
        f1_end_q    <= head.f1_end;
        f1_switch_q <= head.f1_switch;
        f2_end_q    <= head.f2_end;
        f2_switch_q <= head.f2_switch;
        invert_q    <= head.invert;
        gap_q       <= head.gap;
      end
    end
  end

  assign pls_f1_cnt_o    = f1_cnt_q;
  assign pls_f2_cnt_o    = f2_cnt_q;
  assign pls_stop_cnt_o  = stop_cnt_q;
  assign pls_f1_end_o    = f1_end_q;
  assign pls_f1_switch_o = f1_switch_q;
  assign pls_f2_end_o    = f2_end_q;
  assign pls_f2_switch_o = f2_switch_q;
  assign pls_invert_o    = invert_q;
  assign pls_start_o     = (state_q == ST_START);
  assign pls_stop_o      = pls_stop_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign train_done_o    = done_seen && !abort_i;
  assign fill_o          = fill_q;

endmodule

// File: tb/tb_user_pulser_sequencer.sv
// Randomized scoreboard bench for user_pulser_sequencer with a behavioural
// pulser that answers each start with a random-length busy phase then DONE.
module tb_user_pulser_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP_W = 16;

  logic clk = 1'b0;
  logic rst, enable, abort, desc_valid, desc_ready;
  logic [7:0] d_f1c, d_f2c, d_sc, d_rep;
  logic [15:0] d_f1e, d_f1s, d_f2e, d_f2s;
  logic d_inv;
  logic [GAP_W-1:0] d_gap;
  logic [7:0] p_f1c, p_f2c, p_sc;
  logic [15:0] p_f1e, p_f1s, p_f2e, p_f2s;
  logic p_inv, p_start, p_stop, busy, tdone;
  logic [2:0] p_state;
  logic [$clog2(DEPTH):0] fill;

  user_pulser_sequencer #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .abort_i(abort),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
    .desc_f1_cnt_i(d_f1c), .desc_f2_cnt_i(d_f2c), .desc_stop_cnt_i(d_sc),
    .desc_f1_end_i(d_f1e), .desc_f1_switch_i(d_f1s), .desc_f2_end_i(d_f2e),
    .desc_f2_switch_i(d_f2s), .desc_invert_i(d_inv), .desc_repeat_i(d_rep),
    .desc_gap_i(d_gap),
    .pls_f1_cnt_o(p_f1c), .pls_f2_cnt_o(p_f2c), .pls_stop_cnt_o(p_sc),
    .pls_f1_end_o(p_f1e), .pls_f1_switch_o(p_f1s), .pls_f2_end_o(p_f2e),
    .pls_f2_switch_o(p_f2s), .pls_invert_o(p_inv),
    .pls_start_o(p_start), .pls_stop_o(p_stop), .pls_state_i(p_state),
    .busy_o(busy), .train_done_o(tdone), .fill_o(fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  f1c, f2c, sc, rep;
    logic [15:0] f1e, f1s, f2e, f2s;
    logic        inv;
    int          gap;
  } d_t;

  typedef struct {
    logic [88:0] cfg;
    int          rep_idx;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;
  int cyc = 0, start_cnt = 0, done_cnt = 0, last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [88:0] cfg_of(input d_t d);
    return {d.f1c, d.f2c, d.sc, d.f1e, d.f1s, d.f2e, d.f2s, d.inv};
  endfunction

  // Reference model: an accepted descriptor becomes max(repeat,1) identical
  // trains; repeats of the same descriptor start gap+1 cycles after DONE.
  function automatic int model_accept(input d_t d);
    int n;
    exp_t e;
    n = (d.rep == 8'd0) ? 1 : int'(d.rep);
    for (int k = 0; k < n; k++) begin
      e.cfg = cfg_of(d);
      e.rep_idx = k;
      e.gap = d.gap;
      sb.push_back(e);
    end
    return n;
  endfunction

  function automatic d_t rand_desc();
    d_t d;
    d.f1c = 8'($urandom_range(0, 3));
    d.f2c = 8'($urandom_range(0, 3));
    d.sc  = 8'($urandom_range(0, 2));
    d.f1e = 16'($urandom);
    d.f1s = 16'($urandom);
    d.f2e = 16'($urandom);
    d.f2s = 16'($urandom);
    d.inv = 1'($urandom);
    d.rep = 8'($urandom_range(0, 3));
    d.gap = $urandom_range(0, 4);
    return d;
  endfunction

  // Pulser stand-in: zero counts go straight to DONE, otherwise 1..4 busy cycles.
  initial begin
    int cnt;
    logic [2:0] nxt;
    cnt = 0;
    p_state = 3'd0;
    forever begin
      @(negedge clk);
      if (rst || p_stop) begin
        nxt = 3'd0;
        cnt = 0;
      end else if (p_start) begin
        if (p_f1c == 8'd0 && p_f2c == 8'd0 && p_sc == 8'd0) nxt = 3'd4;
        else begin
          cnt = $urandom_range(1, 4);
          nxt = 3'd1;
        end
      end else if (p_state == 3'd1) begin
        cnt--;
        nxt = (cnt == 0) ? 3'd4 : 3'd1;
      end else begin
        nxt = 3'd0;
      end
      @(posedge clk);
      #1 p_state = nxt;
    end
  end

  // Monitor: every start pops one expected train; DONE timestamps feed spacing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (p_start) begin
          start_cnt++;
          if (sb.size() == 0) begin
            check("unexpected_start", 1, 0);
          end else begin
            e = sb.pop_front();
            $display("[TB] start f1_end=%04h rep_idx=%0d cycle=%0d", p_f1e, e.rep_idx, cyc);
            check("start_cfg", {p_f1c, p_f2c, p_sc, p_f1e, p_f1s, p_f2e, p_f2s, p_inv}, e.cfg);
            if (e.rep_idx > 0) check("repeat_spacing", cyc - last_done, e.gap + 1);
          end
        end
        if (tdone) begin
          done_cnt++;
          last_done = cyc;
        end
      end
    end
  end

  // Called and returns at posedge+1; pushes expectations only on acceptance.
  task automatic push_try(input d_t d, input int max_cyc, output bit ok);
    bit acc;
    int n;
    ok = 0;
    {d_f1c, d_f2c, d_sc, d_f1e, d_f1s, d_f2e, d_f2s, d_inv} = cfg_of(d);
    d_rep = d.rep;
    d_gap = GAP_W'(d.gap);
    desc_valid = 1'b1;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      acc = desc_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1;
        n = model_accept(d);
      end
    end
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit idle;
    idle = 0;
    for (int i = 0; i < max_cyc && !idle; i++) begin
      @(negedge clk);
      idle = !busy && (sb.size() == 0) && (fill == '0);
    end
    check(name, idle, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d_t d;
    bit ok, seen;
    int s0, c0, nexp, nacc;

    rst = 1'b1; enable = 1'b0; abort = 1'b0; desc_valid = 1'b0;
    {d_f1c, d_f2c, d_sc, d_f1e, d_f1s, d_f2e, d_f2s, d_inv, d_rep} = '0;
    d_gap = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {busy, tdone, p_start, p_stop, fill, p_f1e, p_f1c, p_inv}, '0);
    check("reset_ready", desc_ready, 1);
    @(posedge clk);
    #1;

    // Single descriptor: start exactly two cycles after the accepting edge.
    enable = 1'b1;
    d = '{f1c: 8'd2, f2c: 8'd0, sc: 8'd0, rep: 8'd1, f1e: 16'd4, f1s: 16'd2,
          f2e: 16'd0, f2s: 16'd0, inv: 1'b0, gap: 0};
    s0 = start_cnt; c0 = done_cnt;
    push_try(d, 5, ok);
    check("t1_accept", ok, 1);
    @(negedge clk);
    check("t1_fill_t1", fill, 1);
    check("t1_nostart_t1", p_start, 0);
    @(negedge clk);
    check("t1_start_t2", p_start, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = tdone;
    end
    check("t1_done_seen", seen, 1);
    @(negedge clk);
    check("t1_idle_after_done", {busy, fill}, 0);
    check("t1_counts", {start_cnt - s0, done_cnt - c0}, {32'd1, 32'd1});
    @(posedge clk);
    #1;

    // Three repeats with gap 5: monitor checks each repeat's 6-cycle spacing.
    d = rand_desc();
    d.f1c = 8'd1; d.rep = 8'd3; d.gap = 5;
    s0 = start_cnt; c0 = done_cnt;
    push_try(d, 5, ok);
    wait_idle("t2_idle", 300);
    check("t2_counts", {start_cnt - s0, done_cnt - c0}, {32'd3, 32'd3});

    // Fill to DEPTH with enable low; fifth push must be refused.
    enable = 1'b0;
    s0 = start_cnt;
    nexp = 0; nacc = 0;
    for (int i = 0; i < 5; i++) begin
      d = rand_desc();
      d.f1e = 16'h0100 + 16'(i);
      d.rep = 8'd1; d.gap = 0;
      push_try(d, (i < 4) ? 3 : 4, ok);
      if (ok) begin
        nacc++;
        nexp++;
      end
    end
    check("t3_accepts", nacc, DEPTH);
    @(negedge clk);
    check("t3_full", {desc_ready, fill}, {1'b0, 3'd4});
    @(posedge clk);
    #1 enable = 1'b1;
    wait_idle("t3_drain", 300);
    check("t3_starts", start_cnt - s0, nexp);

    // Push and pop in one edge at fill = DEPTH-1.
    enable = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      d = rand_desc();
      d.f1e = 16'h0200 + 16'(i);
      d.rep = 8'd1;
      push_try(d, 3, ok);
    end
    @(negedge clk);
    check("t4_fill_before", fill, DEPTH - 1);
    @(posedge clk);
    #1 enable = 1'b1;
    d = rand_desc();
    d.f1e = 16'h02ff; d.rep = 8'd1;
    push_try(d, 1, ok);
    check("t4_push_accepted", ok, 1);
    @(negedge clk);
    check("t4_fill_unchanged", fill, DEPTH - 1);
    @(posedge clk);
    #1;
    wait_idle("t4_drain", 300);

    // Abort in WAIT_DONE with two entries queued; push in the abort cycle dropped.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = rand_desc();
      d.f1c = 8'd1; d.rep = 8'd3; d.gap = 3;
      push_try(d, 3, ok);
    end
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = p_start;
    end
    check("t5_first_start", seen, 1);
    check("t5_queued", fill, 2);
    @(posedge clk);
    #1;
    abort = 1'b1;
    d = rand_desc();
    {d_f1c, d_f2c, d_sc, d_f1e, d_f1s, d_f2e, d_f2s, d_inv} = cfg_of(d);
    desc_valid = 1'b1;
    @(negedge clk);
    check("t5_ready_low_in_abort", desc_ready, 0);
    @(posedge clk);
    #1 abort = 1'b0;
    desc_valid = 1'b0;
    sb.delete();
    s0 = start_cnt;
    @(negedge clk);
    check("t5_stop_pulse", {p_stop, busy, fill}, {1'b1, 1'b0, 3'd0});
    @(negedge clk);
    check("t5_stop_one_cycle", p_stop, 0);
    repeat (20) @(negedge clk);
    check("t5_no_more_starts", start_cnt - s0, 0);
    check("t5_abort_push_dropped", {busy, fill}, 0);
    @(posedge clk);
    #1;

    // All-zero counts with repeat 0: a single immediate-DONE train.
    d = '{f1c: 8'd0, f2c: 8'd0, sc: 8'd0, rep: 8'd0, f1e: 16'h0abc, f1s: 16'd1,
          f2e: 16'd2, f2s: 16'd3, inv: 1'b1, gap: 0};
    s0 = start_cnt; c0 = done_cnt;
    push_try(d, 5, ok);
    wait_idle("t6_idle", 100);
    check("t6_counts", {start_cnt - s0, done_cnt - c0}, {32'd1, 32'd1});

    // Randomized traffic with idle gaps between pushes.
    s0 = start_cnt; c0 = done_cnt; nexp = 0;
    for (int i = 0; i < 25; i++) begin
      d = rand_desc();
      push_try(d, 200, ok);
      check("rand_accept", ok, 1);
      if (ok) nexp += (d.rep == 8'd0) ? 1 : int'(d.rep);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    wait_idle("rand_idle", 3000);
    check("rand_starts", start_cnt - s0, nexp);
    check("rand_dones", done_cnt - c0, nexp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/user_pulser_sequencer.md
# user_pulser_sequencer

Descriptor-driven scheduler for the user-domain pulser.
- Software or a DMA pushes pulse-train descriptors into a small FIFO.
- The sequencer pops each descriptor, drives the pulser configuration and issues a single-cycle start.
- It tracks pulser completion through the pulser's state output, repeats each train a programmed number of times with a programmable gap, then moves on to the next descriptor.
- Abort stops the pulser and flushes all pending work.

## Interface
Parameters:
- DEPTH, 4, descriptor FIFO entries (power of two, ≥2)
- GAP_W, 16, width of the inter-train gap counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- enable_i  in  1  permits popping new descriptors; does not interrupt an active train
- abort_i  in  1  stop pulser, flush FIFO, return to IDLE
- desc_valid_i  in  1  descriptor push request
- desc_ready_o  out  1  FIFO not full and abort_i low
- desc_f1_cnt_i, desc_f2_cnt_i, desc_stop_cnt_i  in  8 each  pulse counts per phase
- desc_f1_end_i, desc_f1_switch_i, desc_f2_end_i, desc_f2_switch_i  in  16 each  period and high-time per phase
- desc_invert_i  in  1  output inversion
- desc_repeat_i  in  8  train repetitions; 0 treated as 1
- desc_gap_i  in  GAP_W  idle cycles after each train
- pls_f1_cnt_o, pls_f2_cnt_o, pls_stop_cnt_o, pls_f1_end_o, pls_f1_switch_o, pls_f2_end_o, pls_f2_switch_o, pls_invert_o  out  matching widths  registered pulser config
- pls_start_o  out  1  one-cycle start
- pls_stop_o  out  1  one-cycle stop
- pls_state_i  in  3  pulser state; 3'd0 IDLE, 3'd4 DONE
- busy_o  out  1  state ≠ IDLE
- train_done_o  out  1  one-cycle pulse per completed train
- fill_o  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO: push when desc_valid_i && desc_ready_o; pop only on the IDLE→START transition. Push and pop in the same cycle are both honoured, and fill is unchanged. A push while full is ignored because ready is low.
- States are IDLE, START, WAIT_DONE and GAP. Reset value is IDLE.
- IDLE: when enable_i && fill≠0, latch the head descriptor into the active registers and pls_* config outputs, pop it, load rep_cnt = max(desc_repeat_i,1), and go to START.
- START: drive pls_start_o=1 for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: wait for pls_state_i==3'd4. On that cycle, train_done_o=1 and rep_cnt decrements.
  - If gap≠0: load gap_cnt=gap and go to GAP.
  - If gap=0: go to START when rep_cnt (after decrement) ≠0, else go to IDLE.
- GAP: decrement gap_cnt each cycle. On the cycle gap_cnt==1, go to START if rep_cnt≠0, else IDLE. The gap is therefore exactly gap cycles.
- Config outputs hold their values from latch until the next descriptor is latched. pls_state_i is not re-checked after start.
- abort_i (any state, highest priority): next cycle state is IDLE, pls_stop_o=1 for one cycle, FIFO is emptied (fill_o=0), rep_cnt and gap_cnt are cleared, and any push in the abort cycle is dropped. Config outputs keep their last values.
- Deasserting enable_i mid-train: the current descriptor, including its repeats and gaps, completes; no further pops occur.
- Arithmetic: 8-bit rep_cnt and GAP_W-bit gap_cnt, no wrap, decrements only when nonzero.

## Timing
- Reset values: all outputs 0 except desc_ready_o, which is 1 on the first cycle after reset.
- Push accepted at edge t: fill_o=1 in cycle t+1, pop and latch at edge t+1, pls_start_o=1 in cycle t+2, WAIT_DONE from cycle t+3.
- Train-to-train spacing, from the DONE cycle to the next pls_start_o:
  - gap=0, repeat pending: 1 cycle.
  - gap=g: g+1 cycles.
  - Next descriptor with gap=0: 2 cycles (via IDLE).
- abort_i in cycle t: pls_stop_o=1 and busy_o=0 in cycle t+1.
- Reset during operation behaves like abort without pls_stop_o: all outputs are driven to reset values at the next edge.

## Test plan
- Single descriptor, f1_cnt=2, f1_end=4, repeat=1, gap=0, push at t -> pls_start_o high at t+2 only; after DONE, one train_done_o pulse; busy_o=0 the following cycle; fill_o returns to 0.
- repeat=3, gap=5 -> exactly 3 pls_start_o and 3 train_done_o pulses; each DONE-to-start spacing is 6 cycles; one pop only.
- Push 5 descriptors back-to-back with DEPTH=4 and enable_i=0 -> desc_ready_o drops after 4 accepts with fill_o=4; setting enable_i=1 drains in order, verified by matching pls_f1_end_o values.
- abort_i during WAIT_DONE with 2 entries queued -> pls_stop_o one cycle, fill_o=0, IDLE, no further starts; a push in the abort cycle is not stored.
- Descriptor with all counts 0, so the pulser goes IDLE→DONE immediately -> DONE detected and train_done_o fires; repeat=0 yields a single train.
- Simultaneous push and pop at fill=DEPTH-1 -> fill unchanged; ordering preserved.
